single_macc_interpolator: RTL and testbench
===========================================

# single_macc_interpolator

Single-MACC polyphase FIR interpolator, the upsampling counterpart of the team's single-MACC decimator. Each accepted input sample produces `InterpK` output samples. One 18x18 multiplier-accumulator walks the polyphase coefficient subsets in turn. It sits on the transmit side, between an 18-bit low-rate sample source and a high-rate consumer, and shares the decimator's coefficient-load and rounding conventions.

## Interface
- `FilterLength`, 16, total taps; must be a multiple of `InterpK`.
- `InterpK`, 2, interpolation factor.
- `TapsPerPhase` (local), `FilterLength/InterpK`, power of two, ≥2.
- `Clk_i` in 1: the single clock. All logic, including coefficient writes, runs on it.
- `Rst_i` in 1: asynchronous, active-high reset.
- `CoeffAddr_i` in clog2(`FilterLength`): coefficient write address. Address n holds tap h[n].
- `CoeffData_i` in 18: signed coefficient.
- `CoeffWr_i` in 1: coefficient write strobe.
- `Data_i` in 18: signed input sample.
- `DataNd_i` in 1: input strobe, 1 cycle.
- `Ready_o` out 1: block accepts `DataNd_i`. Resets to 1.
- `Data_o` out 18: signed output sample. Resets to 0.
- `DataValid_o` out 1: output strobe, 1 cycle. Resets to 0.
- `Overrun_o` out 1: present only under the macro in Configuration. Resets to 0.

## Operation
- **Sample buffer**
  - Circular buffer of `TapsPerPhase` registers. Cleared to 0 on reset.
  - An accepted sample overwrites the oldest entry.
- **Coefficient RAM**
  - Not reset.
  - Read-during-write to the same address returns the old value.
- **Output equation.** For input x[n], phase p=0..K-1 outputs y[nK+p] = Σ_{j=0..T-1} h[p+Kj]·x[n−j]. Phases are emitted in order p=0,1,…
- **FSM**
  - IDLE: `Ready_o`=1. An accepted `DataNd_i` writes the sample and goes to MAC.
  - MAC: issues K·T (coeff, data) address pairs back-to-back. Phase index increments every T issues. After the last issue, returns to IDLE.
- **Pipeline.** Fixed at address → RAM/buffer read register → product register → accumulator. The first product of each phase loads the accumulator (start-of-accumulation flag); every later product adds to it.
- **Arithmetic**
  - Product is 36-bit signed; accumulator is 48-bit signed.
  - Rounding takes acc[37:0]: add 2^19 if non-negative, 2^19−1 if negative, then arithmetic-shift right by 20. This is round-half-away-from-zero.
  - The result saturates to [−131072, 131071].
  - Bits above 37 are ignored (wrap).
- **`DataNd_i` while `Ready_o`=0:** the sample is discarded and the computation in flight is unaffected.
- **Coefficient writes while in MAC** take effect from the next read of that address. Software loads coefficients only while idle.
- **`Rst_i` mid-operation:** aborts immediately. Pending outputs are never emitted, the buffer is cleared, and all outputs return to their reset values.

## Timing
- Let cycle 0 be the cycle in which `DataNd_i`=1 is accepted.
- Phase p address issues occupy cycles 1+pT .. (p+1)T.
- `DataValid_o` pulses at cycle (p+1)·T+4 for each p; outputs are spaced exactly T cycles apart. With the defaults (T=8), outputs appear at cycles 12 and 20.
- `Ready_o`=0 during cycles 1..K·T and returns to 1 at cycle K·T+1, registered. Minimum input spacing is K·T+1 cycles (17 with defaults).
- A new sample accepted at cycle K·T+1 overlaps the draining pipeline. This is legal, and output spacing remains T.

## Configuration
- `SMI_OVERRUN_DET_EN`
  - **Defined:** port `Overrun_o` exists. It is a sticky flag set in the cycle after any `DataNd_i` seen while `Ready_o`=0, and cleared only by `Rst_i`.
  - **Undefined:** the port and logic are absent. Discarded samples are silent.

## Structure
- **Package `smi_pkg`:**
  - widths: data 18, coeff 18, product 36, acc 48, round input 38, round shift 20, output 18;
  - pipeline depth constant 4;
  - FSM state enum {IDLE, MAC}.
- **Sub-module `smi_round_sat`:** registered symmetric rounding plus saturation, 1-cycle latency, strobe passthrough.
- The FSM, buffer and MACC stay in the top module.

## Test plan
- **Impulse.** h[n]=1024·(n+1). Feed `Data_i`=1024, then zeros, one sample every 17 cycles. Required: `Data_o` = 1,2,…,16, then 0s.
- **Latency.** Single `DataNd_i` at cycle 0. Required: `DataValid_o` high only at cycles 12 and 20; `Ready_o` low on cycles 1–16 and high at 17.
- **Rounding.** h[0]=1024, others 0. Inputs 512 / −512 / 511 give phase-0 outputs 1 / −1 / 0, and phase-1 outputs 0.
- **Overrun.** `DataNd_i` at cycles 0 and 5, with the impulse coefficients. Required: the cycle-5 sample is ignored and outputs match the single-sample case. With `SMI_OVERRUN_DET_EN`, `Overrun_o`=1 from cycle 6 until reset.
- **Reset mid-operation.** Assert `Rst_i` at cycle 8. Required: no `DataValid_o`, `Ready_o`=1, `Data_o`=0. A following impulse reproduces the impulse sequence 1..16, since coefficients are retained.
- **Back-to-back.** Inputs 1024 at cycles 0 and 17, with the impulse coefficients. Required: outputs at 12, 20, 29, 37 with values 1, 2, 4, 6.

Source files
------------

// File: rtl/smi_pkg.sv
// Shared widths, pipeline flags and FSM states for the single-MACC polyphase interpolator.
package smi_pkg;

    localparam int unsigned DATA_W     = 18;
    localparam int unsigned COEFF_W    = 18;
    localparam int unsigned PROD_W     = 36;
    localparam int unsigned ACC_W      = 48;
    localparam int unsigned RND_IN_W   = 38;
    localparam int unsigned RND_SHIFT  = 20;
    localparam int unsigned OUT_W      = 18;
    localparam int unsigned PIPE_DEPTH = 4;

    typedef logic signed [DATA_W-1:0]   data_t;
    typedef logic signed [COEFF_W-1:0]  coeff_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic signed [RND_IN_W-1:0] rnd_in_t;
    typedef logic signed [OUT_W-1:0]    out_t;

    // Control bits that travel alongside each MAC issue through the pipeline.
    typedef struct packed {
        logic valid;
        logic sof;
        logic last;
    } pipe_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_e;

endpackage

// File: rtl/smi_round_sat.sv
// Registered round-half-away-from-zero of acc[37:0] by 2^20 with saturation to 18 bits.
module smi_round_sat
    import smi_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  rnd_in_t acc_i,
    input  logic    valid_i,
    output out_t    data_o,
    output logic    valid_o
);

    localparam int unsigned SUM_W = RND_IN_W + 1;
    localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(2 ** (RND_SHIFT - 1));
    localparam logic signed [SUM_W-1:0] HALF_M1 = SUM_W'(2 ** (RND_SHIFT - 1) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(2 ** (OUT_W - 1)));

    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] shr_c;
    out_t                    sat_c;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        sum_c = SUM_W'(acc_i) + (acc_i[RND_IN_W-1] ? HALF_M1 : HALF);
        shr_c = sum_c >>> RND_SHIFT;
        if (shr_c > OUT_MAX) begin
            sat_c = OUT_W'(OUT_MAX);
        end else if (shr_c < OUT_MIN) begin
            sat_c = OUT_W'(OUT_MIN);
        end else begin
            sat_c = OUT_W'(shr_c);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= sat_c;
            end
        end
    end

endmodule

// File: rtl/single_macc_interpolator.sv
// Single-MACC polyphase FIR interpolator: each input sample yields InterpK outputs.
// Optional sticky overrun flag on discarded samples: define SMI_OVERRUN_DET_EN.
module single_macc_interpolator
    import smi_pkg::*;
#(
    parameter int unsigned FilterLength = 16,
    parameter int unsigned InterpK      = 2
) (
    input  logic                            Clk_i,
    input  logic                            Rst_i,
    input  logic [$clog2(FilterLength)-1:0] CoeffAddr_i,
    input  logic [COEFF_W-1:0]              CoeffData_i,
    input  logic                            CoeffWr_i,
    input  logic [DATA_W-1:0]               Data_i,
    input  logic                            DataNd_i,
    output logic                            Ready_o,
    output logic [OUT_W-1:0]                Data_o,
    output logic                            DataValid_o
`ifdef SMI_OVERRUN_DET_EN
    ,
    output logic                            Overrun_o
`endif
);

    localparam int unsigned TapsPerPhase = FilterLength / InterpK;
    localparam int unsigned ADDR_W       = $clog2(FilterLength);
    localparam int unsigned TAP_W        = $clog2(TapsPerPhase);
    localparam int unsigned PH_W         = (InterpK > 1) ? $clog2(InterpK) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TapsPerPhase - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(InterpK - 1);

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               ready_q, ready_d;
    logic               wr_en_c;
    pipe_flags_t        issue_c;

    logic [TAP_W-1:0]   wr_ptr_q;
    data_t              samp_buf_q [TapsPerPhase];
    coeff_t             coeff_ram  [FilterLength];

    logic [ADDR_W-1:0]  coeff_addr_c;
    logic [TAP_W-1:0]   samp_addr_c;

    coeff_t             coeff_rd_q;
    data_t              samp_rd_q;
    pipe_flags_t        s1_q, s2_q;
    prod_t              prod_q;
    acc_t               acc_q;
    logic               acc_v_q;
    logic               unused_acc_hi;

    // Next-state and issue control.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        phase_d = phase_q;
        ready_d = ready_q;
        wr_en_c = 1'b0;
        issue_c = '0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (DataNd_i) begin
                    wr_en_c = 1'b1;
                    ready_d = 1'b0;
                    tap_d   = '0;
                    phase_d = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                issue_c.valid = 1'b1;
                issue_c.sof   = (tap_q == '0);
                issue_c.last  = (tap_q == TAP_LAST);
                if (tap_q == TAP_LAST) begin
                    tap_d = '0;
                    if (phase_q == PH_LAST) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q <= IDLE;
            tap_q   <= '0;
            phase_q <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
        end
    end

    // Tap h[p + K*j] pairs with x[n-j]; wr_ptr_q already points past the newest sample.
    always_comb begin
        coeff_addr_c = ADDR_W'(phase_q) + ADDR_W'(InterpK) * ADDR_W'(tap_q);
        samp_addr_c  = wr_ptr_q - TAP_W'(1) - tap_q;
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            samp_buf_q <= '{default: '0};
            wr_ptr_q   <= '0;
        end else if (wr_en_c) begin
            samp_buf_q[wr_ptr_q] <= Data_i;
            wr_ptr_q             <= wr_ptr_q + TAP_W'(1);
        end
    end

    // Coefficient RAM: unreset, registered read returns the pre-write value.
    always_ff @(posedge Clk_i) begin
        if (CoeffWr_i) begin
            coeff_ram[CoeffAddr_i] <= CoeffData_i;
        end
        coeff_rd_q <= coeff_ram[coeff_addr_c];
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            samp_rd_q <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            acc_v_q   <= 1'b0;
        end else begin
            samp_rd_q <= samp_buf_q[samp_addr_c];
            s1_q      <= issue_c;
            s2_q      <= s1_q;
            prod_q    <= prod_t'(coeff_rd_q) * prod_t'(samp_rd_q);
            if (s2_q.valid) begin
                acc_q <= s2_q.sof ? acc_t'(prod_q) : acc_q + acc_t'(prod_q);
            end
            acc_v_q   <= s2_q.valid & s2_q.last;
        end
    end

    // Accumulator bits above the rounding window wrap and are deliberately dropped.
    assign unused_acc_hi = ^acc_q[ACC_W-1:RND_IN_W];

    smi_round_sat u_round_sat (
        .clk_i   (Clk_i),
        .rst_i   (Rst_i),
        .acc_i   (acc_q[RND_IN_W-1:0]),
        .valid_i (acc_v_q),
        .data_o  (Data_o),
        .valid_o (DataValid_o)
    );

    assign Ready_o = ready_q;

`ifdef SMI_OVERRUN_DET_EN
    logic overrun_q;

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            overrun_q <= 1'b0;
        end else if (DataNd_i && !ready_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign Overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_single_macc_interpolator.sv
// Directed bench for single_macc_interpolator with a reference-model scoreboard.
module tb_single_macc_interpolator;

    localparam int FL = 16;
    localparam int K  = 2;
    localparam int T  = FL / K;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  caddr;
    logic [17:0] cdata;
    logic        cwr;
    logic [17:0] din;
    logic        nd;
    logic        ready;
    logic [17:0] dout;
    logic        dvalid;
`ifdef SMI_OVERRUN_DET_EN
    logic        ovr;
`endif

    always #5 clk = ~clk;

    single_macc_interpolator #(.FilterLength(FL), .InterpK(K)) dut (
        .Clk_i       (clk),
        .Rst_i       (rst),
        .CoeffAddr_i (caddr),
        .CoeffData_i (cdata),
        .CoeffWr_i   (cwr),
        .Data_i      (din),
        .DataNd_i    (nd),
        .Ready_o     (ready),
        .Data_o      (dout),
        .DataValid_o (dvalid)
`ifdef SMI_OVERRUN_DET_EN
        ,
        .Overrun_o   (ovr)
`endif
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ready_at = 0;
    int   ovr_exp  = 0;
    int   h    [FL];
    int   hist [T];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_round(input longint s);
        longint q;
        if (s >= 0) q = (s + 64'sd524288) / 64'sd1048576;
        else        q = -((-s + 64'sd524288) / 64'sd1048576);
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
        return int'(q);
    endfunction

    task automatic accept(input int d);
        longint s;
        exp_t   e;
        for (int j = T - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = d;
        for (int p = 0; p < K; p++) begin
            s = 0;
            for (int j = 0; j < T; j++) s += longint'(h[p + K*j]) * longint'(hist[j]);
            e.val = ref_round(s);
            e.cyc = cyc + (p + 1) * T + 4;
            sb.push_back(e);
        end
        ready_at = cyc + K * T + 1;
    endtask

    task automatic observe();
        exp_t e;
        chk("ready", int'(ready), (cyc >= ready_at) ? 1 : 0);
        if (dvalid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("valid_when_none_due", int'(dvalid), 0);
            end else begin
                e = sb.pop_front();
                chk("data", int'($signed(dout)), e.val);
                chk("out_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("missing_valid", int'(dvalid), 1);
            void'(sb.pop_front());
        end
`ifdef SMI_OVERRUN_DET_EN
        chk("overrun", int'(ovr), ovr_exp);
`endif
    endtask

    task automatic step(input bit n, input int d);
        @(negedge clk);
        cyc++;
        observe();
        nd  = n;
        din = 18'(d);
        if (n) begin
            if (cyc >= ready_at) accept(d);
            else                 ovr_exp = 1;
        end
    endtask

    // mode 0: impulse set h[n]=1024(n+1); mode 1: h[0]=1024 only
    task automatic load(input int mode);
        int v;
        for (int n = 0; n < FL; n++) begin
            @(negedge clk);
            cyc++;
            observe();
            nd    = 1'b0;
            v     = (mode == 0) ? 1024 * (n + 1) : ((n == 0) ? 1024 : 0);
            cwr   = 1'b1;
            caddr = 4'(n);
            cdata = 18'(v);
            h[n]  = v;
        end
        @(negedge clk);
        cyc++;
        observe();
        cwr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        observe();
        rst      = 1'b1;
        nd       = 1'b0;
        cwr      = 1'b0;
        sb.delete();
        ready_at = 0;
        ovr_exp  = 0;
        hist     = '{default: 0};
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_data", int'($signed(dout)), 0);
        chk("rst_valid", int'(dvalid), 0);
`ifdef SMI_OVERRUN_DET_EN
        chk("rst_overrun", int'(ovr), 0);
`endif
        repeat (2) step(1'b0, 0);
        @(negedge clk);
        cyc++;
        observe();
        rst = 1'b0;
    endtask

    task automatic impulse_run();
        for (int s = 0; s < 9; s++) begin
            step(1'b1, (s == 0) ? 1024 : 0);
            repeat (16) step(1'b0, 0);
        end
        repeat (8) step(1'b0, 0);
    endtask

    initial begin
        rst   = 1'b1;
        nd    = 1'b0;
        din   = '0;
        cwr   = 1'b0;
        caddr = '0;
        cdata = '0;
        hist  = '{default: 0};
        h     = '{default: 0};

        do_reset();

        // Impulse response 1..16 then zeros; also covers latency and ready timing.
        load(0);
        impulse_run();

        // Rounding: +/-half rounds away from zero, just-below-half rounds to zero.
        load(1);
        step(1'b1, 512);  repeat (16) step(1'b0, 0);
        step(1'b1, -512); repeat (16) step(1'b0, 0);
        step(1'b1, 511);  repeat (16) step(1'b0, 0);
        repeat (8) step(1'b0, 0);

        // Overrun: second strobe while busy is dropped.
        load(0);
        do_reset();
        step(1'b1, 1024);
        repeat (4) step(1'b0, 0);
        step(1'b1, 777);
        repeat (25) step(1'b0, 0);

        // Reset at cycle 8 of a computation, then coefficients must survive.
        step(1'b1, 1024);
        repeat (7) step(1'b0, 0);
        do_reset();
        impulse_run();

        // Back-to-back at the minimum spacing.
        do_reset();
        step(1'b1, 1024);
        repeat (16) step(1'b0, 0);
        step(1'b1, 1024);
        repeat (25) step(1'b0, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
